// File: rtl/axi_rw_sched_pkg.sv
// Shared types and constants for the AXI read/write burst scheduler.
package axi_rw_sched_pkg;

    // Scheduler states: one burst is owned at a time.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WDATA = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4
    } state_e;

    // Grant encoding; the value doubles as the requester index into rr_arb2.
    typedef enum logic {
        GRANT_W = 1'b0,
        GRANT_R = 1'b1
    } grant_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Fixed 32-bit beats: byte address -> word address drops the low bits.
    localparam int BEAT_BYTES = 4;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

endpackage

// File: rtl/axi_rw_sched_rr_arb2.sv
// Two-requester round-robin arbiter. Requester 0 is write, requester 1 is read.
module rr_arb2
    import axi_rw_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    grant_e last_q;
    grant_e last_d;

    // Grant decode: a lone requester wins; on a tie the one not granted last time wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_q == GRANT_R) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Remember the winner only when the granted handshake actually completes.
    always_comb begin
        last_d = last_q;
        if (advance && (grant != 2'b00)) begin
            last_d = grant[0] ? GRANT_W : GRANT_R;
        end
    end

    // Last-grant register; resets to read so write wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            last_q <= GRANT_R;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/axi_rw_sched.sv
// Burst scheduler sharing one single-port synchronous-read RAM between AXI
// write and read channels. Owns one INCR burst at a time, sequences word
// addresses, and produces the B response and R beats.
module axi_rw_sched
    import axi_rw_sched_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              aw_valid,
    output logic              aw_ready,
    input  logic [ADDR_W-1:0] aw_addr,
    input  logic [7:0]        aw_len,
    input  logic              aw_id,
    input  logic              ar_valid,
    output logic              ar_ready,
    input  logic [ADDR_W-1:0] ar_addr,
    input  logic [7:0]        ar_len,
    input  logic              ar_id,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic              w_last,
    input  logic [DATA_W-1:0] w_data,
    input  logic [3:0]        w_strb,
    output logic              b_valid,
    input  logic              b_ready,
    output logic [1:0]        b_resp,
    output logic              b_id,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [DATA_W-1:0] r_data,
    output logic [1:0]        r_resp,
    output logic              r_last,
    output logic              r_id,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int WADDR_W = ADDR_W - BEAT_SHIFT;

    state_e             state_q, state_d;
    logic [WADDR_W-1:0] addr_q, addr_d;
    logic [7:0]         len_q, len_d;
    logic [7:0]         beat_cnt_q, beat_cnt_d;
    logic               id_q, id_d;
    logic               err_q, err_d;

    logic [1:0] arb_req;
    logic [1:0] arb_grant;
    logic       in_idle;
    logic       aw_hs;
    logic       ar_hs;
    logic       last_beat;

    assign in_idle   = (state_q == ST_IDLE);
    assign arb_req   = in_idle ? {ar_valid, aw_valid} : 2'b00;
    assign aw_ready  = arb_grant[0];
    assign ar_ready  = arb_grant[1];
    assign aw_hs     = aw_valid & aw_ready;
    assign ar_hs     = ar_valid & ar_ready;
    assign last_beat = (beat_cnt_q == len_q);

    // Write data is forwarded untouched; mem_we decides whether it lands.
    assign mem_wdata = w_data;
    assign mem_wstrb = w_strb;

    rr_arb2 u_arb (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .req     (arb_req),
        .advance (aw_hs | ar_hs),
        .grant   (arb_grant)
    );

    // Next-state, burst bookkeeping and state-decoded outputs.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        id_d       = id_q;
        err_d      = err_q;

        w_ready  = (state_q == ST_WDATA);
        mem_we   = (state_q == ST_WDATA) && w_valid;
        mem_en   = mem_we || (state_q == ST_RADDR);
        mem_addr = addr_q;
        b_valid  = (state_q == ST_WRESP);
        b_resp   = (b_valid && err_q) ? RESP_SLVERR : RESP_OKAY;
        b_id     = b_valid ? id_q : 1'b0;
        r_valid  = (state_q == ST_RDATA);
        r_data   = r_valid ? mem_rdata : '0;
        r_resp   = RESP_OKAY;
        r_last   = r_valid && last_beat;
        r_id     = r_valid ? id_q : 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (aw_hs) begin
                    addr_d     = aw_addr[ADDR_W-1:BEAT_SHIFT];
                    len_d      = aw_len;
                    id_d       = aw_id;
                    beat_cnt_d = 8'd0;
                    state_d    = ST_WDATA;
                end else if (ar_hs) begin
                    addr_d     = ar_addr[ADDR_W-1:BEAT_SHIFT];
                    len_d      = ar_len;
                    id_d       = ar_id;
                    beat_cnt_d = 8'd0;
                    state_d    = ST_RADDR;
                end
            end
            ST_WDATA: begin
                if (w_valid) begin
                    addr_d     = addr_q + 1'b1;
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    // A misplaced or missing w_last is reported, but the burst
                    // length always comes from the captured len.
                    if (w_last != last_beat) begin
                        err_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = ST_WRESP;
                    end
                end
            end
            ST_WRESP: begin
                if (b_ready) begin
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_RADDR: begin
                state_d = ST_RDATA;
            end
            ST_RDATA: begin
                if (r_ready) begin
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end else begin
                        addr_d     = addr_q + 1'b1;
                        beat_cnt_d = beat_cnt_q + 8'd1;
                        state_d    = ST_RADDR;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and burst-context registers; reset abandons any burst in flight.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= 8'd0;
            beat_cnt_q <= 8'd0;
            id_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            id_q       <= id_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_axi_rw_sched.sv
// Self-checking bench for axi_rw_sched: directed scenarios plus randomized
// bursts checked against a word-array reference of the RAM contents.
module tb_axi_rw_sched;
    import axi_rw_sched_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int WORDS  = 1 << (ADDR_W - 2);

    logic              ACLK;
    logic              ARESETN;
    logic              aw_valid, aw_ready, aw_id;
    logic [ADDR_W-1:0] aw_addr;
    logic [7:0]        aw_len;
    logic              ar_valid, ar_ready, ar_id;
    logic [ADDR_W-1:0] ar_addr;
    logic [7:0]        ar_len;
    logic              w_valid, w_ready, w_last;
    logic [DATA_W-1:0] w_data;
    logic [3:0]        w_strb;
    logic              b_valid, b_ready, b_id;
    logic [1:0]        b_resp;
    logic              r_valid, r_ready, r_last, r_id;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              mem_en, mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [3:0]        mem_wstrb;

    logic [DATA_W-1:0] ram     [WORDS];
    logic [DATA_W-1:0] exp_mem [WORDS];

    int n_checks = 0;
    int n_pass   = 0;

    axi_rw_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len), .aw_id(aw_id),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len), .ar_id(ar_id),
        .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last), .w_data(w_data), .w_strb(w_strb),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp), .b_id(b_id),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_id(r_id),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Single-port synchronous-read RAM: read data appears the cycle after
    // mem_en and is held while mem_en is low.
    always @(posedge ACLK) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wstrb[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle_inputs();
        aw_valid = 0; aw_addr = '0; aw_len = 8'd0; aw_id = 0;
        ar_valid = 0; ar_addr = '0; ar_len = 8'd0; ar_id = 0;
        w_valid = 0; w_last = 0; w_data = '0; w_strb = 4'h0;
        b_ready = 0; r_ready = 0;
    endtask

    task automatic apply_reset();
        drive_idle_inputs();
        ARESETN = 1'b0;
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
    endtask

    // Full write burst. last_at is the beat index carrying w_last (-1: never).
    task automatic write_burst(input logic [ADDR_W-1:0] addr, input int len, input logic id,
                               input int last_at, input bit seq_data, input bit jitter,
                               output logic [1:0] resp_seen);
        logic [ADDR_W-3:0] waddr;
        logic              exp_err;
        @(negedge ACLK);
        aw_valid = 1; aw_addr = addr; aw_len = 8'(len); aw_id = id;
        #1;
        n_checks++;
        if (aw_ready !== 1'b1 || ar_ready !== 1'b0)
            $display("FAIL wr_aw_grant: aw_ready=%b ar_ready=%b want 1/0", aw_ready, ar_ready);
        else n_pass++;
        @(negedge ACLK);
        aw_valid = 0;
        waddr    = addr[ADDR_W-1:2];
        exp_err  = 1'b0;
        for (int i = 0; i <= len; i++) begin
            repeat (jitter ? $urandom_range(0, 2) : 0) begin
                w_valid = 0;
                #1;
                n_checks++;
                if (mem_en !== 1'b0 || w_ready !== 1'b1)
                    $display("FAIL wr_gap: mem_en=%b w_ready=%b want 0/1", mem_en, w_ready);
                else n_pass++;
                @(negedge ACLK);
            end
            w_valid = 1;
            w_data  = seq_data ? 32'(i) : $urandom();
            w_strb  = jitter ? 4'($urandom()) : 4'hF;
            w_last  = (i == last_at);
            #1;
            n_checks++;
            if ({w_ready, mem_en, mem_we} !== 3'b111 || mem_addr !== waddr ||
                mem_wdata !== w_data || mem_wstrb !== w_strb)
                $display("FAIL wr_beat %0d: rdy/en/we=%b%b%b addr=%h data=%h want 111 addr=%h data=%h",
                         i, w_ready, mem_en, mem_we, mem_addr, mem_wdata, waddr, w_data);
            else n_pass++;
            for (int b = 0; b < 4; b++) begin
                if (w_strb[b]) exp_mem[waddr][8*b +: 8] = w_data[8*b +: 8];
            end
            if (w_last != (i == len)) exp_err = 1'b1;
            waddr = waddr + 1'b1;
            @(negedge ACLK);
        end
        w_valid = 0; w_last = 0;
        #1;
        n_checks++;
        if (b_valid !== 1'b1 || w_ready !== 1'b0 || b_id !== id ||
            b_resp !== (exp_err ? RESP_SLVERR : RESP_OKAY))
            $display("FAIL wr_bresp: b_valid=%b w_ready=%b b_id=%b b_resp=%b want 1 0 %b %b",
                     b_valid, w_ready, b_id, b_resp, id, exp_err ? RESP_SLVERR : RESP_OKAY);
        else n_pass++;
        resp_seen = b_resp;
        repeat (jitter ? $urandom_range(0, 2) : 0) @(negedge ACLK);
        b_ready = 1;
        @(negedge ACLK);
        b_ready = 0;
        #1;
        n_checks++;
        if (b_valid !== 1'b0)
            $display("FAIL wr_bdone: b_valid=%b want 0", b_valid);
        else n_pass++;
    endtask

    // Full read burst checked beat by beat against exp_mem.
    task automatic read_burst(input logic [ADDR_W-1:0] addr, input int len, input logic id,
                              input bit jitter);
        logic [ADDR_W-3:0] raddr;
        int                guard;
        @(negedge ACLK);
        ar_valid = 1; ar_addr = addr; ar_len = 8'(len); ar_id = id;
        #1;
        n_checks++;
        if (ar_ready !== 1'b1 || aw_ready !== 1'b0)
            $display("FAIL rd_ar_grant: ar_ready=%b aw_ready=%b want 1/0", ar_ready, aw_ready);
        else n_pass++;
        @(negedge ACLK);
        ar_valid = 0;
        raddr    = addr[ADDR_W-1:2];
        for (int i = 0; i <= len; i++) begin
            #1;
            n_checks++;
            if ({mem_en, mem_we, r_valid} !== 3'b100 || mem_addr !== raddr)
                $display("FAIL rd_addr %0d: en/we/rv=%b%b%b addr=%h want 100 addr=%h",
                         i, mem_en, mem_we, r_valid, mem_addr, raddr);
            else n_pass++;
            @(negedge ACLK);
            r_ready = jitter ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            guard = 0;
            while (r_ready !== 1'b1) begin
                n_checks++;
                if (r_valid !== 1'b1 || mem_en !== 1'b0)
                    $display("FAIL rd_stall %0d: r_valid=%b mem_en=%b want 1/0", i, r_valid, mem_en);
                else n_pass++;
                @(negedge ACLK);
                guard++;
                r_ready = (guard > 6) ? 1'b1 : 1'($urandom_range(0, 1));
                #1;
            end
            n_checks++;
            if (r_valid !== 1'b1 || r_data !== exp_mem[raddr] || r_last !== (i == len) ||
                r_id !== id || r_resp !== RESP_OKAY)
                $display("FAIL rd_beat %0d: rv=%b data=%h last=%b id=%b resp=%b want 1 %h %b %b %b",
                         i, r_valid, r_data, r_last, r_id, r_resp, exp_mem[raddr], (i == len), id, RESP_OKAY);
            else n_pass++;
            @(negedge ACLK);
            r_ready = 0;
            raddr   = raddr + 1'b1;
        end
        #1;
        n_checks++;
        if (r_valid !== 1'b0 || mem_en !== 1'b0)
            $display("FAIL rd_done: r_valid=%b mem_en=%b want 0/0", r_valid, mem_en);
        else n_pass++;
    endtask

    task automatic test_reset();
        drive_idle_inputs();
        ARESETN = 1'b0;
        @(negedge ACLK);
        #1;
        n_checks++;
        if ({aw_ready, ar_ready, w_ready, b_valid, r_valid, mem_en, mem_we, b_resp, r_last, b_id, r_id} !== 12'd0)
            $display("FAIL reset_ctrl: got %b want 0", {aw_ready, ar_ready, w_ready, b_valid, r_valid,
                     mem_en, mem_we, b_resp, r_last, b_id, r_id});
        else n_pass++;
        n_checks++;
        if (mem_addr !== '0 || r_data !== '0)
            $display("FAIL reset_data: mem_addr=%h r_data=%h want 0", mem_addr, r_data);
        else n_pass++;
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        ar_valid = 1;
        #1;
        n_checks++;
        if ({aw_ready, ar_ready} !== 2'b01)
            $display("FAIL lone_ar_grant: aw/ar_ready=%b want 01", {aw_ready, ar_ready});
        else n_pass++;
        ar_valid = 0; aw_valid = 1;
        #1;
        n_checks++;
        if ({aw_ready, ar_ready} !== 2'b10)
            $display("FAIL lone_aw_grant: aw/ar_ready=%b want 10", {aw_ready, ar_ready});
        else n_pass++;
        aw_valid = 0;
    endtask

    task automatic test_single_write();
        logic [1:0] resp;
        write_burst(10'h100, 7, 1'b0, 7, 1'b1, 1'b0, resp);
        n_checks++;
        if (resp !== RESP_OKAY) $display("FAIL single_write_resp: got %b want %b", resp, RESP_OKAY);
        else n_pass++;
    endtask

    task automatic test_readback();
        read_burst(10'h100, 7, 1'b0, 1'b0);
    endtask

    // Both valids held through each burst: grants must alternate W,R,W,R.
    task automatic test_concurrent();
        logic exp_w;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            exp_w = (k % 2 == 0);
            @(negedge ACLK);
            aw_valid = 1; aw_addr = 10'h080; aw_len = 8'd0; aw_id = 1;
            ar_valid = 1; ar_addr = 10'h080; ar_len = 8'd0; ar_id = 1;
            #1;
            n_checks++;
            if ({aw_ready, ar_ready} !== {exp_w, ~exp_w})
                $display("FAIL tie_grant %0d: aw/ar_ready=%b want %b", k, {aw_ready, ar_ready}, {exp_w, ~exp_w});
            else n_pass++;
            @(negedge ACLK);
            if (exp_w) begin
                w_valid = 1; w_last = 1; w_strb = 4'hF; w_data = 32'hA5A5_0000 + 32'(k);
                exp_mem[8'h20] = w_data;
                #1;
                n_checks++;
                if ({aw_ready, ar_ready} !== 2'b00)
                    $display("FAIL busy_ready_w %0d: aw/ar_ready=%b want 00", k, {aw_ready, ar_ready});
                else n_pass++;
                @(negedge ACLK);
                w_valid = 0; w_last = 0;
                #1;
                n_checks++;
                if (b_valid !== 1'b1 || b_id !== 1'b1 || b_resp !== RESP_OKAY || {aw_ready, ar_ready} !== 2'b00)
                    $display("FAIL tie_bresp %0d: b_valid=%b b_id=%b b_resp=%b want 1 1 00", k, b_valid, b_id, b_resp);
                else n_pass++;
                b_ready = 1; aw_valid = 0; ar_valid = 0;
                @(negedge ACLK);
                b_ready = 0;
            end else begin
                #1;
                n_checks++;
                if ({aw_ready, ar_ready} !== 2'b00 || mem_en !== 1'b1)
                    $display("FAIL busy_ready_r %0d: aw/ar_ready=%b mem_en=%b want 00 1", k, {aw_ready, ar_ready}, mem_en);
                else n_pass++;
                @(negedge ACLK);
                r_ready = 1;
                #1;
                n_checks++;
                if (r_valid !== 1'b1 || r_data !== exp_mem[8'h20] || r_last !== 1'b1 || {aw_ready, ar_ready} !== 2'b00)
                    $display("FAIL tie_rbeat %0d: r_valid=%b r_data=%h r_last=%b want 1 %h 1", k, r_valid, r_data, r_last, exp_mem[8'h20]);
                else n_pass++;
                aw_valid = 0; ar_valid = 0;
                @(negedge ACLK);
                r_ready = 0;
            end
        end
    endtask

    task automatic test_early_wlast();
        logic [1:0] resp;
        write_burst(10'h040, 3, 1'b1, 1, 1'b0, 1'b0, resp);
        n_checks++;
        if (resp !== RESP_SLVERR) $display("FAIL early_wlast_resp: got %b want %b", resp, RESP_SLVERR);
        else n_pass++;
        read_burst(10'h040, 3, 1'b1, 1'b0);
        write_burst(10'h040, 3, 1'b1, 3, 1'b0, 1'b0, resp);
        n_checks++;
        if (resp !== RESP_OKAY) $display("FAIL after_err_resp: got %b want %b", resp, RESP_OKAY);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [1:0] resp;
        write_burst(10'h3F8, 3, 1'b0, 3, 1'b1, 1'b0, resp);
        read_burst(10'h3F8, 3, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        @(negedge ACLK);
        aw_valid = 1; aw_addr = 10'h200; aw_len = 8'd7; aw_id = 1;
        @(negedge ACLK);
        aw_valid = 0;
        for (int i = 0; i < 2; i++) begin
            w_valid = 1; w_last = 0; w_strb = 4'hF; w_data = 32'hC0DE_0000 + 32'(i);
            exp_mem[8'h80 + i] = w_data;
            @(negedge ACLK);
        end
        w_valid = 1; w_data = 32'hDEAD_BEEF;
        #2;
        ARESETN = 1'b0;
        #1;
        n_checks++;
        if ({aw_ready, ar_ready, w_ready, b_valid, r_valid, mem_en, mem_we, b_resp, r_last, b_id, r_id} !== 12'd0 ||
            mem_addr !== '0 || r_data !== '0)
            $display("FAIL mid_reset_outputs: ctrl=%b mem_addr=%h want 0", {aw_ready, ar_ready, w_ready, b_valid,
                     r_valid, mem_en, mem_we, b_resp, r_last, b_id, r_id}, mem_addr);
        else n_pass++;
        @(negedge ACLK);
        drive_idle_inputs();
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        aw_valid = 1; aw_addr = 10'h300; aw_len = 8'd0; aw_id = 0;
        ar_valid = 1; ar_addr = 10'h300; ar_len = 8'd0; ar_id = 0;
        #1;
        n_checks++;
        if ({aw_ready, ar_ready} !== 2'b10)
            $display("FAIL post_reset_grant: aw/ar_ready=%b want 10", {aw_ready, ar_ready});
        else n_pass++;
        @(negedge ACLK);
        aw_valid = 0; ar_valid = 0;
        w_valid = 1; w_last = 1; w_strb = 4'hF; w_data = 32'h1234_5678;
        exp_mem[8'hC0] = w_data;
        @(negedge ACLK);
        w_valid = 0; w_last = 0;
        #1;
        n_checks++;
        if (b_valid !== 1'b1 || b_resp !== RESP_OKAY)
            $display("FAIL post_reset_bresp: b_valid=%b b_resp=%b want 1 00", b_valid, b_resp);
        else n_pass++;
        b_ready = 1;
        @(negedge ACLK);
        b_ready = 0;
        read_burst(10'h200, 1, 1'b0, 1'b0);
        read_burst(10'h300, 0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [1:0]        resp;
        logic [ADDR_W-1:0] a;
        int                l;
        int                la;
        // Max-length burst covers the whole word space so every address is known.
        write_burst(10'h000, 255, 1'b0, 255, 1'b0, 1'b0, resp);
        for (int n = 0; n < 30; n++) begin
            a = ADDR_W'($urandom());
            l = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 3))
                    0:       la = $urandom_range(0, l);
                    1:       la = -1;
                    default: la = l;
                endcase
                write_burst(a, l, 1'($urandom()), la, 1'b0, 1'b1, resp);
            end else begin
                read_burst(a, l, 1'($urandom()), 1'b1);
            end
        end
    endtask

    initial begin
        ARESETN = 1'b0;
        drive_idle_inputs();
        test_reset();
        test_single_write();
        test_readback();
        test_concurrent();
        test_early_wlast();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_rw_sched.md
# axi_rw_sched

Burst scheduler that shares one single-port, synchronous-read register RAM between the AXI4 write and read channels of the CDC AXI slave. It round-robin arbitrates accepted AW/AR address phases, owns one burst at a time, and sequences per-beat RAM addresses for INCR, 32-bit bursts. It generates the B response and the R beats. It sits between the slave's AXI port logic and the display-parameter RAM.

## Interface
- ADDR_W, 10: byte-address width into the RAM space; RAM word address is ADDR_W-2 bits
- DATA_W, 32: data width; beat size is fixed at 4 bytes
- ACLK  in  1  sole clock
- ARESETN  in  1  asynchronous, active-low reset
- aw_valid / aw_ready  in / out  1  write address handshake
- aw_addr, aw_len, aw_id  in  ADDR_W, 8, 1  write burst start address, beats-1, ID
- ar_valid / ar_ready  in / out  1  read address handshake
- ar_addr, ar_len, ar_id  in  ADDR_W, 8, 1  read burst start address, beats-1, ID
- w_valid / w_ready  in / out  1  write beat handshake
- w_last  in  1  master's last-beat marker
- w_data, w_strb  in  DATA_W, 4  forwarded unchanged to mem_wdata, mem_wstrb
- b_valid / b_ready  out / in  1  write response handshake
- b_resp, b_id  out  2, 1  write response and captured ID
- r_valid / r_ready  out / in  1  read beat handshake
- r_data, r_resp, r_last, r_id  out  DATA_W, 2, 1, 1  read beat fields
- mem_en, mem_we  out  1  RAM enable; write enable
- mem_addr  out  ADDR_W-2  RAM word address
- mem_wdata, mem_wstrb  out  DATA_W, 4  RAM write data and byte enables
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en; the RAM holds it while mem_en=0

## Operation
- States: IDLE, WDATA, WRESP, RADDR, RDATA.
- IDLE, arbitration:
  - aw_ready = aw_valid & grant_w; ar_ready = ar_valid & ~grant_w.
  - If only one valid is high, that channel is granted.
  - If both are high, the channel not granted last time wins.
  - last_grant resets to READ, so write wins the first tie.
- On handshake: capture the address as a word address (addr[ADDR_W-1:2]), the len, and the id. Clear beat_cnt. Update last_grant. Go to WDATA or RADDR.
- WDATA:
  - w_ready=1.
  - On a w_valid beat: mem_en=mem_we=1 at the current address; the address increments by one word; beat_cnt increments.
  - The beat where beat_cnt==len goes to WRESP.
  - err latches if w_last differs from (beat_cnt==len) on any beat.
- WRESP:
  - b_valid=1, b_resp = err ? SLVERR : OKAY, b_id = the captured ID.
  - On b_ready go to IDLE and clear err.
- RADDR: mem_en=1, mem_we=0. Unconditionally go to RDATA.
- RDATA:
  - r_valid=1, r_data=mem_rdata (pass-through), r_resp=OKAY, r_last=(beat_cnt==len), r_id = the captured ID.
  - On r_ready: if last, go to IDLE; otherwise increment the address and beat_cnt and go to RADDR.
- Address arithmetic: the word address wraps modulo 2^(ADDR_W-2); wraparound is not an error. aw_addr[1:0] and ar_addr[1:0] are ignored. Only INCR is supported; burst type and size are not inputs.

## Timing
- Reset values, all outputs: 0 (ready, valid, mem_en, mem_we, b_resp, r_last, addresses). State=IDLE, last_grant=READ, err=0.
- ARESETN asserted mid-burst returns the block to IDLE immediately. The burst is abandoned, with no B or R response.
- Address handshake at cycle T:
  - Write: w_ready is high from T+1. One beat per cycle is accepted. If the last beat lands at cycle L, b_valid rises at L+1.
  - Read: mem_en at T+1; r_valid at T+2. Each beat takes 2 cycles minimum.
- Response handshake at cycle H: IDLE at H+1. A new aw_ready/ar_ready may assert at H+1.
- At most one of aw_ready and ar_ready is high in any cycle. Neither is high outside IDLE.
- aw_ready and ar_ready are combinational from the valids in IDLE only. All other outputs are state-decoded.

## Structure
- Package axi_rw_sched_pkg:
  - state enum
  - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - BEAT_BYTES=4
  - grant encoding (GRANT_W, GRANT_R)
- Sub-module rr_arb2: 2-requester round-robin arbiter.
  - Ports: req[1:0], grant[1:0], advance (update last_grant), clock, reset.
  - Instantiated once for the AW/AR decision.

## Test plan
- Single write burst: aw_addr=0x100, len=7, w_data 0..7, w_last on beat 8 -> mem_we on 8 consecutive cycles at word addresses 0x40..0x47; then b_valid with b_resp=OKAY, b_id=0.
- Read-back: ar_addr=0x100, len=7 after the write -> 8 r beats with data 0..7, r_last only on the 8th beat, 2 cycles per beat with r_ready held high.
- Concurrent traffic: aw_valid and ar_valid asserted together 4 times from reset -> grants alternate W, R, W, R; aw_ready and ar_ready are never high together.
- Early w_last: len=3 with w_last on beat 2 -> all 4 beats are written; b_resp=SLVERR; the next burst returns OKAY.
- Wrap: ADDR_W=10, aw_addr=0x3F8, len=3 -> mem_addr sequence is 0xFE, 0xFF, 0x00, 0x01.
- Reset mid-operation: ARESETN low during WDATA beat 3 of 8 -> all outputs are 0 immediately; after release the block accepts a fresh AW with a write-first grant.
